// File: rtl/rstseq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_e      : sequencer states
//   LOSS_CNT_W   : width of the lock-loss event counter
//   MAX_CHANNELS : largest number of reset domains the sequencer supports
package rstseq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    DELAY     = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int LOSS_CNT_W   = 8;
  localparam int MAX_CHANNELS = 8;

endpackage

// File: rtl/reset_sequencer_sync2.sv
// Two-flop synchroniser for a single asynchronous level signal.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both flops clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronised output (two-cycle latency)
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer between the PLL and the SoC cores. Filters PLL lock, waits
// RELEASE_DELAY cycles, then releases CHANNELS reset domains in order, STAGGER
// cycles apart. Lock loss or a software request re-runs the sequence.
//   clk_core        : core clock (PLL output)
//   reset_n         : asynchronous active-low reset
//   pll_locked      : raw PLL lock, asynchronous to clk_core
//   sw_reset_req    : synchronous level request to re-run the sequence
//   rst_n_out       : per-domain active-low resets, bit 0 released first
//   pll_stable      : lock has passed the filter
//   seq_done        : every domain is released
//   lock_loss_count : saturating count of lock-loss events
// Build option: define RSTSEQ_LOSS_COUNT_EN to compile in the lock-loss
// counter; otherwise lock_loss_count reads constant zero.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int LOCK_FILTER   = 4,
  parameter int RELEASE_DELAY = 128,
  parameter int CHANNELS      = 2,
  parameter int STAGGER       = 16
) (
  input  logic                  clk_core,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic [CHANNELS-1:0]   rst_n_out,
  output logic                  pll_stable,
  output logic                  seq_done,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int DLY_W = $clog2(RELEASE_DELAY + 1);
  localparam int STG_W = $clog2(STAGGER + 1);
  localparam int IDX_W = $clog2(CHANNELS + 1);

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RELEASE_DELAY - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  if (LOCK_FILTER < 1) begin : g_chk_filter
    $error("LOCK_FILTER must be at least 1");
  end
  if (RELEASE_DELAY < 1) begin : g_chk_delay
    $error("RELEASE_DELAY must be at least 1");
  end
  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_chk_channels
    $error("CHANNELS must be in 1..8");
  end
  if (STAGGER < 1) begin : g_chk_stagger
    $error("STAGGER must be at least 1");
  end

  logic lock_s;

  sync2 u_lock_sync (
    .clk_i  (clk_core),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  state_e                 state_q,     state_d;
  logic [LOCK_FILTER-1:0] filter_q,    filter_d;
  logic [DLY_W-1:0]       dly_cnt_q,   dly_cnt_d;
  logic [STG_W-1:0]       stg_cnt_q,   stg_cnt_d;
  logic [IDX_W-1:0]       idx_q,       idx_d;
  logic [CHANNELS-1:0]    rst_n_out_q, rst_n_out_d;
  logic                   pll_stable_q, pll_stable_d;
  logic                   seq_done_q,  seq_done_d;
`ifdef RSTSEQ_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0]  loss_cnt_q,  loss_cnt_d;
`endif

  // Lock loss outranks the software request; neither applies in WAIT_LOCK.
  logic lock_abort;
  logic sw_abort;
  logic filter_full;

  assign lock_abort  = (state_q != WAIT_LOCK) && !lock_s;
  assign sw_abort    = (state_q != WAIT_LOCK) && lock_s && sw_reset_req;
  assign filter_full = &filter_q;

  // State register.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (lock_abort) begin
      state_d = WAIT_LOCK;
    end else if (sw_abort) begin
      state_d = DELAY;
    end else begin
      case (state_q)
        WAIT_LOCK: if (filter_full) state_d = DELAY;
        DELAY:     if (dly_cnt_q == DLY_LAST) state_d = (CHANNELS == 1) ? RUN : RELEASE;
        RELEASE:   if (stg_cnt_q == STG_LAST && idx_q == IDX_LAST) state_d = RUN;
        RUN:       state_d = RUN;
        default:   state_d = WAIT_LOCK;
      endcase
    end
  end

  // Output and counter next values.
  always_comb begin
    filter_d     = (filter_q << 1) | LOCK_FILTER'(lock_s);
    dly_cnt_d    = dly_cnt_q;
    stg_cnt_d    = stg_cnt_q;
    idx_d        = idx_q;
    rst_n_out_d  = rst_n_out_q;
    pll_stable_d = pll_stable_q;
    seq_done_d   = seq_done_q;
`ifdef RSTSEQ_LOSS_COUNT_EN
    loss_cnt_d   = loss_cnt_q;
`endif
    if (lock_abort) begin
      filter_d     = '0;
      dly_cnt_d    = '0;
      stg_cnt_d    = '0;
      idx_d        = '0;
      rst_n_out_d  = '0;
      pll_stable_d = 1'b0;
      seq_done_d   = 1'b0;
`ifdef RSTSEQ_LOSS_COUNT_EN
      if (pll_stable_q && !(&loss_cnt_q)) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
`endif
    end else if (sw_abort) begin
      // Held requests keep re-entering DELAY with the counter at zero.
      dly_cnt_d   = '0;
      stg_cnt_d   = '0;
      idx_d       = '0;
      rst_n_out_d = '0;
      seq_done_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (filter_full) begin
            pll_stable_d = 1'b1;
            dly_cnt_d    = '0;
          end
        end
        DELAY: begin
          if (dly_cnt_q == DLY_LAST) begin
            rst_n_out_d[0] = 1'b1;
            if (CHANNELS == 1) begin
              seq_done_d = 1'b1;
            end else begin
              idx_d     = IDX_W'(1);
              stg_cnt_d = '0;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + DLY_W'(1);
          end
        end
        RELEASE: begin
          if (stg_cnt_q == STG_LAST) begin
            for (int k = 0; k < CHANNELS; k++) begin
              if (idx_q == IDX_W'(k)) rst_n_out_d[k] = 1'b1;
            end
            stg_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              seq_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            stg_cnt_d = stg_cnt_q + STG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      filter_q     <= '0;
      dly_cnt_q    <= '0;
      stg_cnt_q    <= '0;
      idx_q        <= '0;
      rst_n_out_q  <= '0;
      pll_stable_q <= 1'b0;
      seq_done_q   <= 1'b0;
`ifdef RSTSEQ_LOSS_COUNT_EN
      loss_cnt_q   <= '0;
`endif
    end else begin
      filter_q     <= filter_d;
      dly_cnt_q    <= dly_cnt_d;
      stg_cnt_q    <= stg_cnt_d;
      idx_q        <= idx_d;
      rst_n_out_q  <= rst_n_out_d;
      pll_stable_q <= pll_stable_d;
      seq_done_q   <= seq_done_d;
`ifdef RSTSEQ_LOSS_COUNT_EN
      loss_cnt_q   <= loss_cnt_d;
`endif
    end
  end

  assign rst_n_out  = rst_n_out_q;
  assign pll_stable = pll_stable_q;
  assign seq_done   = seq_done_q;
`ifdef RSTSEQ_LOSS_COUNT_EN
  assign lock_loss_count = loss_cnt_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations share one stimulus stream.
// A reference model derives expected outputs from "cycles since the sequence
// started" arithmetic; expectations are queued per edge and a monitor on the
// falling edge pops and compares them.
module tb_reset_sequencer;

  localparam int W = 18;  // {rst_n_out (8, zero-extended), pll_stable, seq_done, count (8)}

  logic clk;
  logic reset_n;
  logic pll_locked;
  logic sw_reset_req;

  logic [1:0] rst_a;  logic stable_a; logic done_a; logic [7:0] loss_a;
  logic [0:0] rst_b;  logic stable_b; logic done_b; logic [7:0] loss_b;
  logic [7:0] rst_c;  logic stable_c; logic done_c; logic [7:0] loss_c;

  int n_cmp;
  int n_fail;

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  logic [W-1:0] exp_qc[$];

  reset_sequencer #(.LOCK_FILTER(4), .RELEASE_DELAY(128), .CHANNELS(2), .STAGGER(16)) dut_a (
    .clk_core(clk), .reset_n(reset_n), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
    .rst_n_out(rst_a), .pll_stable(stable_a), .seq_done(done_a), .lock_loss_count(loss_a));

  reset_sequencer #(.LOCK_FILTER(1), .RELEASE_DELAY(1), .CHANNELS(1), .STAGGER(1)) dut_b (
    .clk_core(clk), .reset_n(reset_n), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
    .rst_n_out(rst_b), .pll_stable(stable_b), .seq_done(done_b), .lock_loss_count(loss_b));

  reset_sequencer #(.LOCK_FILTER(2), .RELEASE_DELAY(3), .CHANNELS(8), .STAGGER(2)) dut_c (
    .clk_core(clk), .reset_n(reset_n), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
    .rst_n_out(rst_c), .pll_stable(stable_c), .seq_done(done_c), .lock_loss_count(loss_c));

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // p1/ls: lock as seen one and two edges late; ones: consecutive synchronised
  // highs since the filter was last cleared; t: edges since the sequence
  // (re)started; losses: lock-loss events seen while stable.
  typedef struct {
    int p1;
    int ls;
    int ones;
    int stable;
    int t;
    int losses;
  } mdl_t;

  mdl_t m_a, m_b, m_c;

  function automatic mdl_t mdl_step(mdl_t m, logic rst_n, logic pll, logic sw, int lf);
    mdl_t n;
    n = m;
    if (!rst_n) begin
      n = '{default: 0};
      return n;
    end
    n.p1 = int'(pll);
    n.ls = m.p1;
    if (m.stable != 0) begin
      if (m.ls == 0) begin
        n.stable = 0;
        n.ones   = 0;
        n.losses = (m.losses < 255) ? m.losses + 1 : 255;
      end else begin
        n.ones = (m.ones + 1 > lf) ? lf : m.ones + 1;
        n.t    = (sw === 1'b1) ? 0 : m.t + 1;
      end
    end else begin
      if (m.ones >= lf) begin
        n.stable = 1;
        n.t      = 0;
      end
      n.ones = (m.ls != 0) ? ((m.ones + 1 > lf) ? lf : m.ones + 1) : 0;
    end
    return n;
  endfunction

  function automatic logic [W-1:0] mdl_exp(mdl_t m, int rd, int ch, int st);
    int         rel;
    logic [8:0] mask;
    logic [7:0] cnt;
    rel = 0;
    if (m.stable != 0 && m.t >= rd) rel = 1 + (m.t - rd) / st;
    if (rel > ch) rel = ch;
    mask = (9'd1 << rel) - 9'd1;
`ifdef RSTSEQ_LOSS_COUNT_EN
    cnt = 8'(m.losses);
`else
    cnt = 8'd0;
`endif
    return {mask[7:0], (m.stable != 0), (m.stable != 0 && rel == ch), cnt};
  endfunction

  always @(posedge clk) begin
    m_a = mdl_step(m_a, reset_n, pll_locked, sw_reset_req, 4);
    m_b = mdl_step(m_b, reset_n, pll_locked, sw_reset_req, 1);
    m_c = mdl_step(m_c, reset_n, pll_locked, sw_reset_req, 2);
    exp_qa.push_back(mdl_exp(m_a, 128, 2, 16));
    exp_qb.push_back(mdl_exp(m_b, 1, 1, 1));
    exp_qc.push_back(mdl_exp(m_c, 3, 8, 2));
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_qa.size() > 0) check("dut_a", {8'(rst_a), stable_a, done_a, loss_a}, exp_qa.pop_front());
    if (exp_qb.size() > 0) check("dut_b", {8'(rst_b), stable_b, done_b, loss_b}, exp_qb.pop_front());
    if (exp_qc.size() > 0) check("dut_c", {8'(rst_c), stable_c, done_c, loss_c}, exp_qc.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic pll, input logic sw, input int n);
    pll_locked   = pll;
    sw_reset_req = sw;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_release0(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (rst_a[0] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_release0: domain 0 not released within 400 cycles");
    end
  endtask

  task automatic wait_stable(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (stable_a === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_stable: pll_stable not seen within 100 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    int low_left;
    reset_n      = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Glitchy lock, then steady lock and a full sequence.
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 1);
    hold(1'b1, 1'b0, 170);

    // One-cycle software request in RUN.
    hold(1'b1, 1'b1, 1);
    hold(1'b1, 1'b0, 150);

    // Held software request.
    hold(1'b1, 1'b1, 5);
    hold(1'b1, 1'b0, 150);

    // Lock loss in RUN, then relock.
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 170);

    // Software request together with lock loss.
    hold(1'b0, 1'b1, 4);
    hold(1'b1, 1'b0, 170);

    // Asynchronous reset while dut_a sits in DELAY.
    hold(1'b0, 1'b0, 3);
    pll_locked = 1'b1;
    wait_stable(got);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_a", {8'(rst_a), stable_a, done_a, loss_a}, '0);
    check("async_rst_b", {8'(rst_b), stable_b, done_b, loss_b}, '0);
    check("async_rst_c", {8'(rst_c), stable_c, done_c, loss_c}, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hold(1'b1, 1'b0, 170);

    // Random lock drop-outs and software requests.
    low_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (low_left == 0 && $urandom_range(0, 149) == 0) low_left = $urandom_range(1, 6);
      pll_locked   = (low_left == 0);
      sw_reset_req = ($urandom_range(0, 29) == 0);
      if (low_left > 0) low_left--;
      @(negedge clk);
    end

    // Repeated lock loss after domain 0 only.
    for (int i = 0; i < 300; i++) begin
      pll_locked   = 1'b1;
      sw_reset_req = 1'b0;
      wait_release0(got);
      if (!got) break;
      repeat ($urandom_range(0, 8)) @(negedge clk);
      hold(1'b0, 1'b0, $urandom_range(1, 3));
    end
    hold(1'b1, 1'b0, 10);
`ifdef RSTSEQ_LOSS_COUNT_EN
    check("loss_saturate", {10'd0, loss_a}, {10'd0, 8'd255});
`else
    check("loss_disabled", {10'd0, loss_a}, {10'd0, 8'd0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "time limit");
  end

endmodule
